// File: rtl/spm_product_collector.sv
// ---------------------------------------------------------------------------
// spm_product_collector
//
// Purpose:
//   Collects the LSB-first serial product stream of the serial-parallel
//   multiplier (spm) and reassembles it into a 2*WIDTH-bit parallel word.
//   The word is offered on a valid/ready handshake so that core logic or a
//   pad-side readout can take the product without sampling the serial pin.
//
// Parameters:
//   WIDTH       operand width of the spm. The product and the capture window
//               are both 2*WIDTH (bits / cycles).
//
// Ports:
//   clk         system clock, rising edge
//   rst         synchronous active-high reset
//   start       one-cycle pulse in the cycle the spm starts a multiply;
//               product bit 0 is sampled on the following cycle
//   p           serial product bit, LSB-first
//   prod        assembled product, stable while prod_valid=1
//   prod_valid  product available
//   prod_ready  consumer accepts prod this cycle
//   busy        high while capturing (SHIFT) or holding (HOLD)
//   overrun     sticky: a start arrived while busy and was dropped
//   prod_par    (only with SPM_COLLECT_PARITY_EN) XOR reduction of prod,
//               registered together with prod
//
// Optional feature macro: SPM_COLLECT_PARITY_EN
// ---------------------------------------------------------------------------
module spm_product_collector #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               p,
   output logic [2*WIDTH-1:0] prod,
   output logic               prod_valid,
   input  logic               prod_ready,
   output logic               busy,
   output logic               overrun
`ifdef SPM_COLLECT_PARITY_EN
   ,
   output logic               prod_par
`endif
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(PW);
   localparam logic [CW-1:0] CNT_LAST = CW'(PW - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_HOLD  = 2'd2
   } state_t;

   state_t          state_q;
   logic [PW-1:0]   sr_q;
   logic [PW-1:0]   sr_d;
   logic [CW-1:0]   cnt_q;
   logic [PW-1:0]   prod_q;
   logic            prod_valid_q;
   logic            busy_q;
   logic            overrun_q;
   logic            handshake_s;

`ifdef SPM_COLLECT_PARITY_EN
   logic            prod_par_q;

   // Even/odd parity of a full product word.
   function automatic logic parity_f(input logic [PW-1:0] word);
      return ^word;
   endfunction
`endif

   // Next shift-register value: new bit enters at the MSB so that after
   // PW captures the first (LSB) bit has arrived at bit 0.
   always_comb begin
      sr_d        = {p, sr_q[PW-1:1]};
      handshake_s = prod_valid_q & prod_ready;
   end

   // Capture FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         sr_q         <= '0;
         cnt_q        <= '0;
         prod_q       <= '0;
         prod_valid_q <= 1'b0;
         busy_q       <= 1'b0;
         overrun_q    <= 1'b0;
`ifdef SPM_COLLECT_PARITY_EN
         prod_par_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q <= ST_SHIFT;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end

            ST_SHIFT: begin
               sr_q  <= sr_d;
               cnt_q <= cnt_q + CW'(1);
               // A start during capture cannot be honoured; flag and drop it.
               if (start) begin
                  overrun_q <= 1'b1;
               end
               if (cnt_q == CNT_LAST) begin
                  // Load the completed word including the bit arriving now.
                  prod_q       <= sr_d;
                  prod_valid_q <= 1'b1;
                  state_q      <= ST_HOLD;
                  cnt_q        <= '0;
`ifdef SPM_COLLECT_PARITY_EN
                  prod_par_q   <= parity_f(sr_d);
`endif
               end
            end

            ST_HOLD: begin
               if (handshake_s) begin
                  prod_valid_q <= 1'b0;
                  if (start) begin
                     // Back-to-back: prod keeps its old value until the
                     // next product completes.
                     state_q <= ST_SHIFT;
                     cnt_q   <= '0;
                  end else begin
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                  end
               end else if (start) begin
                  overrun_q <= 1'b1;
               end
            end

            default: begin
               state_q      <= ST_IDLE;
               cnt_q        <= '0;
               prod_valid_q <= 1'b0;
               busy_q       <= 1'b0;
            end
         endcase
      end
   end

   assign prod       = prod_q;
   assign prod_valid = prod_valid_q;
   assign busy       = busy_q;
   assign overrun    = overrun_q;
`ifdef SPM_COLLECT_PARITY_EN
   assign prod_par   = prod_par_q;
`endif

endmodule

// File: tb/tb_spm_product_collector.sv
// ---------------------------------------------------------------------------
// tb_spm_product_collector
//
// Self-checking bench for spm_product_collector (WIDTH=8). Table-driven
// capture vectors plus hand-written sequences for backpressure, back-to-back
// starts, overrun, mid-capture reset and idle stability.
// ---------------------------------------------------------------------------
module tb_spm_product_collector;

   localparam int WIDTH = 8;
   localparam int PW    = 2 * WIDTH;

   logic          clk;
   logic          rst;
   logic          start;
   logic          p;
   logic [PW-1:0] prod;
   logic          prod_valid;
   logic          prod_ready;
   logic          busy;
   logic          overrun;
`ifdef SPM_COLLECT_PARITY_EN
   logic          prod_par;
`endif

   int checks   = 0;
   int failures = 0;

   spm_product_collector #(.WIDTH(WIDTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .p          (p),
      .prod       (prod),
      .prod_valid (prod_valid),
      .prod_ready (prod_ready),
      .busy       (busy),
      .overrun    (overrun)
`ifdef SPM_COLLECT_PARITY_EN
      ,
      .prod_par   (prod_par)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [PW-1:0] word;      // stream driven LSB-first
      logic [PW-1:0] exp_prod;  // expected assembled product
      logic          exp_par;   // expected XOR reduction
   } vec_t;

   vec_t vecs [5];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      p     = 1'b0;
      tick();
      start = 1'b0;
   endtask

   // Drive bits [first..last] of word, one per clock.
   task automatic stream(input logic [PW-1:0] word, input int first, input int last);
      for (int i = first; i <= last; i++) begin
         p = word[i];
         tick();
      end
      p = 1'b0;
   endtask

   task automatic handshake();
      prod_ready = 1'b1;
      tick();
      prod_ready = 1'b0;
   endtask

   initial begin
      vecs[0] = '{word: 16'h000F, exp_prod: 16'h000F, exp_par: 1'b0};
      vecs[1] = '{word: 16'hFFFA, exp_prod: 16'hFFFA, exp_par: 1'b0};
      vecs[2] = '{word: 16'hA5A5, exp_prod: 16'hA5A5, exp_par: 1'b0};
      vecs[3] = '{word: 16'h0001, exp_prod: 16'h0001, exp_par: 1'b1};
      vecs[4] = '{word: 16'h8000, exp_prod: 16'h8000, exp_par: 1'b1};

      rst = 1'b1; start = 1'b0; p = 1'b0; prod_ready = 1'b0;
      tick();
      tick();
      rst = 1'b0;

      // Reset state.
      check("reset_prod",    32'(prod),       32'h0);
      check("reset_valid",   32'(prod_valid), 32'h0);
      check("reset_busy",    32'(busy),       32'h0);
      check("reset_overrun", 32'(overrun),    32'h0);
`ifdef SPM_COLLECT_PARITY_EN
      check("reset_par",     32'(prod_par),   32'h0);
`endif

      // Table-driven captures: latency, value, release.
      for (int v = 0; v < 5; v++) begin
         pulse_start();
         check("start_busy", 32'(busy), 32'h1);
         stream(vecs[v].word, 0, PW - 2);
         check("pre_last_valid", 32'(prod_valid), 32'h0);
         stream(vecs[v].word, PW - 1, PW - 1);
         check("cap_valid", 32'(prod_valid), 32'h1);
         check("cap_prod",  32'(prod),       32'(vecs[v].exp_prod));
`ifdef SPM_COLLECT_PARITY_EN
         check("cap_par",   32'(prod_par),   32'(vecs[v].exp_par));
`endif
         handshake();
         check("rel_valid", 32'(prod_valid), 32'h0);
         check("rel_busy",  32'(busy),       32'h0);
      end

      // Backpressure then back-to-back start.
      pulse_start();
      stream(16'h1234, 0, PW - 1);
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_valid", 32'(prod_valid), 32'h1);
         check("bp_prod",  32'(prod),       32'h1234);
      end
`ifdef SPM_COLLECT_PARITY_EN
      check("bp_par", 32'(prod_par), 32'h1);
`endif
      prod_ready = 1'b1;
      start      = 1'b1;
      tick();
      prod_ready = 1'b0;
      start      = 1'b0;
      check("b2b_valid_drop", 32'(prod_valid), 32'h0);
      check("b2b_busy",       32'(busy),       32'h1);
      check("b2b_prod_kept",  32'(prod),       32'h1234);
      stream(16'hABCD, 0, PW - 2);
      check("b2b_pre_valid", 32'(prod_valid), 32'h0);
      stream(16'hABCD, PW - 1, PW - 1);
      check("b2b_valid",   32'(prod_valid), 32'h1);
      check("b2b_prod",    32'(prod),       32'hABCD);
      check("b2b_overrun", 32'(overrun),    32'h0);
`ifdef SPM_COLLECT_PARITY_EN
      check("b2b_par",     32'(prod_par),   32'h0);
`endif
      // A start while holding without handshake is dropped.
      start = 1'b1;
      tick();
      start = 1'b0;
      check("hold_drop_overrun", 32'(overrun),    32'h1);
      check("hold_drop_valid",   32'(prod_valid), 32'h1);
      check("hold_drop_prod",    32'(prod),       32'hABCD);
      handshake();
      check("hold_drop_idle",    32'(busy),       32'h0);

      // Clear overrun, then start again 4 cycles into SHIFT.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("ovr_cleared", 32'(overrun), 32'h0);
      pulse_start();
      stream(16'h5A3C, 0, 3);
      start = 1'b1;
      stream(16'h5A3C, 4, 4);
      start = 1'b0;
      check("ovr_set", 32'(overrun), 32'h1);
      stream(16'h5A3C, 5, PW - 1);
      check("ovr_valid",  32'(prod_valid), 32'h1);
      check("ovr_prod",   32'(prod),       32'h5A3C);
      check("ovr_sticky", 32'(overrun),    32'h1);
      handshake();
      check("ovr_sticky2", 32'(overrun), 32'h1);
      check("ovr_idle",    32'(busy),    32'h0);

      // Reset mid-capture after 9 bits.
      pulse_start();
      stream(16'hFFFF, 0, 8);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_prod",    32'(prod),       32'h0);
      check("mid_rst_valid",   32'(prod_valid), 32'h0);
      check("mid_rst_busy",    32'(busy),       32'h0);
      check("mid_rst_overrun", 32'(overrun),    32'h0);
      pulse_start();
      stream(16'h8001, 0, PW - 1);
      check("after_rst_valid", 32'(prod_valid), 32'h1);
      check("after_rst_prod",  32'(prod),       32'h8001);
      handshake();

      // Idle stability with random p and no start.
      for (int i = 0; i < 40; i++) begin
         p = 1'($urandom_range(1, 0));
         prod_ready = 1'($urandom_range(1, 0));
         tick();
         check("idle_valid", 32'(prod_valid), 32'h0);
         check("idle_busy",  32'(busy),       32'h0);
      end
      prod_ready = 1'b0;
      check("idle_prod", 32'(prod), 32'h8001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/spm_product_collector.md
Name: spm_product_collector

Overview:
- Downstream neighbour of the serial-parallel multiplier (spm).
- Consumes the spm serial product output `p`, which arrives LSB-first, one bit per clock.
- Reassembles it into a 2*WIDTH-bit parallel word and presents that word on a valid/ready handshake.
- Lets core logic or a pad-side readout take the product without sampling the serial pin itself.

Parameters:
- WIDTH, 8, operand width of the spm. The product is 2*WIDTH bits and the capture window is 2*WIDTH cycles.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  single-cycle pulse marking the cycle in which the spm begins a multiply. First product bit is sampled on the next cycle.
- p  input  1  serial product bit from spm, LSB-first
- prod  output  2*WIDTH  assembled product; stable while prod_valid=1
- prod_valid  output  1  product available
- prod_ready  input  1  consumer accepts prod this cycle
- busy  output  1  high while in SHIFT or HOLD
- overrun  output  1  sticky flag: a start was dropped

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE, prod=0, prod_valid=0, busy=0, overrun=0.
  - The shift register and bit counter are cleared.
  - Reset overrides everything, including a capture or hold in progress. The partial product is discarded.
- States: IDLE, SHIFT, HOLD.
- IDLE:
  - start=1 → SHIFT, counter=0, busy=1 from the next cycle.
  - start=0 → stay in IDLE.
- SHIFT:
  - Every cycle, sr <= {p, sr[2W-1:1]} (right shift, new bit in at the MSB) and counter increments.
  - The cycle after start captures product bit 0. Capture number 2W (counter = 2W-1) captures bit 2W-1.
  - On that last capture, prod is loaded with the completed word {p, sr[2W-1:1]}, prod_valid=1 on the next cycle, and state → HOLD.
  - Latency: prod_valid rises 2W+1 clocks after the start cycle (17 for WIDTH=8).
- HOLD:
  - prod and prod_valid are held until the handshake prod_valid & prod_ready.
  - Handshake cycle with start=0: prod_valid=0 next cycle, state → IDLE, busy=0.
  - Handshake cycle with start=1: back-to-back. prod_valid=0 next cycle, state → SHIFT, counter=0, busy stays 1, and the next cycle captures bit 0 of the new product. prod retains its old value until the new product loads.
- Dropped starts:
  - start=1 in SHIFT, or in HOLD without a handshake, is ignored. overrun is set and stays 1 until reset.
  - The current capture or hold is unaffected.
- prod_ready while prod_valid=0 has no effect.
- The product is treated as raw bits; no sign handling or arithmetic is applied. Two's-complement spm results pass through bit-exact.
- The counter is $clog2(2*WIDTH) bits. It never wraps within a capture because it returns to 0 on leaving SHIFT.

Optional Feature:
- Macro: SPM_COLLECT_PARITY_EN
- Defined:
  - Adds output port prod_par (1 bit) = XOR reduction of the product word.
  - prod_par is registered in the same cycle as prod, valid exactly when prod_valid=1, and reset to 0.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Basic capture (WIDTH=8): reset, start pulse, drive p with the bits of 16'h000F LSB-first (1,1,1,1, then twelve 0s) → prod_valid rises 17 cycles after start, prod=16'h000F. With prod_ready=1, prod_valid drops on the next cycle and busy=0.
- Signed pattern: p stream of 16'hFFFA (-2*3) → prod=16'hFFFA. With SPM_COLLECT_PARITY_EN defined, prod_par=0 (14 ones).
- Backpressure plus back-to-back: capture 16'h1234, hold prod_ready=0 for 5 cycles → prod_valid and prod stable at 16'h1234. Then assert prod_ready and start in the same cycle while streaming 16'hABCD → the second product appears 17 cycles later with overrun=0.
- Overrun: start pulse again 4 cycles into SHIFT → overrun=1 and stays 1. The current capture still completes and prod equals the original stream.
- Reset mid-operation: assert rst after 9 captured bits → prod=0, prod_valid=0, busy=0 next cycle. A fresh start followed by 16'h8001 yields prod=16'h8001.
- Idle stability: toggle p randomly with start=0 for 40 cycles → prod_valid stays 0 and busy stays 0.
